// File: rtl/mmss_timer_if.sv
// Control and display bundle of the minutes:seconds timer.
// The controller side (buttons/debouncers) uses master; the timer core uses slave.
interface mmss_timer_if;
  logic       pause;
  logic       clr;
  logic       dir;
  logic       adj;
  logic       sel;
  logic       lap;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic [6:0] lap_min;
  logic [5:0] lap_sec;
  logic       lap_valid;
  logic       expired;
  logic       tick_1hz;

  modport master (
    output pause, clr, dir, adj, sel, lap,
    input  minutes, seconds, lap_min, lap_sec, lap_valid, expired, tick_1hz
  );

  modport slave (
    input  pause, clr, dir, adj, sel, lap,
    output minutes, seconds, lap_min, lap_sec, lap_valid, expired, tick_1hz
  );
endinterface

// File: rtl/mmss_timer.sv
// Single-clock minutes:seconds stopwatch/countdown core.
// A second prescaler and an adjust prescaler generate clock enables; all
// time, lap and flag state lives in registers updated from one next-state block.
module mmss_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int ADJ_HZ  = 2,
  parameter int MIN_MAX = 59
) (
  input  logic          clk,
  input  logic          rst,
  mmss_timer_if.slave   bus
);

  localparam int ADJ_P = CLK_HZ / ADJ_HZ;
  localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int ADJ_W = (ADJ_P > 1) ? $clog2(ADJ_P) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_P - 1);
  localparam logic [6:0]       MIN_TOP  = 7'(MIN_MAX);

  logic [SEC_W-1:0] sec_cnt_reg, sec_cnt_next;
  logic [ADJ_W-1:0] adj_cnt_reg, adj_cnt_next;
  logic [6:0]       minutes_reg, minutes_next;
  logic [5:0]       seconds_reg, seconds_next;
  logic [6:0]       lap_min_reg, lap_min_next;
  logic [5:0]       lap_sec_reg, lap_sec_next;
  logic             lap_valid_reg, lap_valid_next;
  logic             expired_reg, expired_next;
  logic             tick_reg, tick_next;
  logic             sec_tick;
  logic             adj_step;

  // Next-state logic: prescalers, then time update with clr > adj_step > sec_tick.
  always_comb begin
    sec_cnt_next   = sec_cnt_reg;
    adj_cnt_next   = adj_cnt_reg;
    minutes_next   = minutes_reg;
    seconds_next   = seconds_reg;
    lap_min_next   = lap_min_reg;
    lap_sec_next   = lap_sec_reg;
    lap_valid_next = lap_valid_reg;
    expired_next   = expired_reg;
    tick_next      = 1'b0;

    sec_tick = (sec_cnt_reg == SEC_LAST) && !bus.pause && !bus.adj;
    adj_step = bus.adj && (adj_cnt_reg == ADJ_LAST);

    // Second prescaler freezes its phase during pause/adjust.
    if (!bus.pause && !bus.adj) begin
      sec_cnt_next = sec_tick ? '0 : sec_cnt_reg + 1'b1;
    end
    // Adjust prescaler restarts each time adjust mode is entered.
    if (!bus.adj) begin
      adj_cnt_next = '0;
    end else begin
      adj_cnt_next = adj_step ? '0 : adj_cnt_reg + 1'b1;
    end

    if (bus.clr) begin
      sec_cnt_next   = '0;
      adj_cnt_next   = '0;
      minutes_next   = '0;
      seconds_next   = '0;
      lap_min_next   = '0;
      lap_sec_next   = '0;
      lap_valid_next = 1'b0;
      expired_next   = 1'b0;
    end else begin
      // Lap samples the value registered this cycle, before any update.
      if (bus.lap) begin
        lap_min_next   = minutes_reg;
        lap_sec_next   = seconds_reg;
        lap_valid_next = 1'b1;
      end
      if (adj_step) begin
        if (bus.sel) begin
          seconds_next = (seconds_reg == 6'd59) ? 6'd0 : seconds_reg + 6'd1;
        end else begin
          minutes_next = (minutes_reg == MIN_TOP) ? 7'd0 : minutes_reg + 7'd1;
        end
        expired_next = 1'b0;
      end else if (sec_tick && !expired_reg) begin
        // A tick that only holds at a limit is not a count update: no strobe.
        if (!bus.dir) begin
          if (minutes_reg == MIN_TOP && seconds_reg == 6'd59) begin
            expired_next = 1'b1;
          end else begin
            tick_next = 1'b1;
            if (seconds_reg == 6'd59) begin
              seconds_next = 6'd0;
              minutes_next = minutes_reg + 7'd1;
            end else begin
              seconds_next = seconds_reg + 6'd1;
            end
          end
        end else begin
          if (minutes_reg == 7'd0 && seconds_reg == 6'd0) begin
            expired_next = 1'b1;
          end else begin
            tick_next = 1'b1;
            if (seconds_reg == 6'd0) begin
              seconds_next = 6'd59;
              minutes_next = minutes_reg - 7'd1;
            end else begin
              seconds_next = seconds_reg - 6'd1;
              if (minutes_reg == 7'd0 && seconds_reg == 6'd1) begin
                expired_next = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // State register; reset discards all state including prescaler phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_cnt_reg   <= '0;
      adj_cnt_reg   <= '0;
      minutes_reg   <= '0;
      seconds_reg   <= '0;
      lap_min_reg   <= '0;
      lap_sec_reg   <= '0;
      lap_valid_reg <= 1'b0;
      expired_reg   <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      sec_cnt_reg   <= sec_cnt_next;
      adj_cnt_reg   <= adj_cnt_next;
      minutes_reg   <= minutes_next;
      seconds_reg   <= seconds_next;
      lap_min_reg   <= lap_min_next;
      lap_sec_reg   <= lap_sec_next;
      lap_valid_reg <= lap_valid_next;
      expired_reg   <= expired_next;
      tick_reg      <= tick_next;
    end
  end

  assign bus.minutes   = minutes_reg;
  assign bus.seconds   = seconds_reg;
  assign bus.lap_min   = lap_min_reg;
  assign bus.lap_sec   = lap_sec_reg;
  assign bus.lap_valid = lap_valid_reg;
  assign bus.expired   = expired_reg;
  assign bus.tick_1hz  = tick_reg;

endmodule

// File: doc/mmss_timer.md
# mmss_timer

Parametrised minutes:seconds stopwatch/countdown core that replaces the divided-clock time counter with a single-clock, clock-enable design. It generates its own 1 Hz and adjust-rate strobes from `clk` and counts up or down. It supports pause, field adjust, lap capture and a sticky limit flag. It sits between the button debouncers and the digit-split/cathode/display path, and its `minutes`/`seconds` outputs feed digit extraction directly.

## Interface
- `CLK_HZ`, 100_000_000: `clk` frequency; cycles per counted second.
- `ADJ_HZ`, 2: adjust-step rate; adjust period = CLK_HZ/ADJ_HZ cycles (integer, ≥1).
- `MIN_MAX`, 59: largest minute value, 1..99.

- `clk`  in  1  system clock; only clock in the block.
- `rst`  in  1  asynchronous, active-low reset.
- `pause`  in  1  level; 1 holds count and prescaler.
- `clr`  in  1  sync pulse; time to 00:00, clears `expired` and `lap_valid`.
- `dir`  in  1  0 = count up, 1 = count down.
- `adj`  in  1  level; 1 = adjust mode, normal counting suspended.
- `sel`  in  1  adjust field: 0 = minutes, 1 = seconds.
- `lap`  in  1  sync pulse; capture current time.
- `minutes`  out  7  current minutes, 0..MIN_MAX.
- `seconds`  out  6  current seconds, 0..59.
- `lap_min`  out  7  captured minutes.
- `lap_sec`  out  6  captured seconds.
- `lap_valid`  out  1  a lap has been captured since reset/clr.
- `expired`  out  1  sticky; limit reached.
- `tick_1hz`  out  1  one-cycle strobe, coincident with each count update.

## Operation
- All outputs reset to 0 while `rst`=0. No output is X after reset.
- Second prescaler counts 0..CLK_HZ-1. Terminal count produces `sec_tick`.
  - Holds while `pause`=1 or `adj`=1.
  - Zeroed by `clr`.
- Adjust prescaler counts 0..CLK_HZ/ADJ_HZ-1, only while `adj`=1. It is zeroed whenever `adj`=0, and terminal count produces `adj_step`.
- Per-cycle priority: `clr` > `adj_step` > (`sec_tick` and not `pause` and not `adj`).
- Up count (`dir`=0):
  - sec 59 → 0 with min+1.
  - At MIN_MAX:59 the next tick holds the value and sets `expired`.
- Down count (`dir`=1):
  - sec 0 → 59 with min−1.
  - A tick that yields 00:00 sets `expired`.
  - A tick at 00:00 holds and sets `expired`.
- While `expired`=1, ticks do not change the time and `tick_1hz` stays 0.
- `adj_step`, `sel`=0: min+1, wrapping MIN_MAX → 0; seconds untouched.
- `adj_step`, `sel`=1: sec+1, wrapping 59 → 0 with no carry into minutes.
- Any `adj_step` clears `expired`.
- `dir` may change at any time; it takes effect on the next tick.
- `lap`:
  - Captures `minutes`/`seconds` as registered in that cycle, i.e. the pre-update value if a tick coincides.
  - Sets `lap_valid`.
  - Ignored in a cycle where `clr`=1.
- `clr` overrides a simultaneous tick, `adj_step` or `lap`.

## Timing
- All outputs registered.
- `sec_tick` at prescaler terminal count in cycle N updates `minutes`/`seconds`/`expired` and asserts `tick_1hz` at the N+1 edge.
- First count update after reset or `clr` is exactly CLK_HZ unpaused cycles later.
- Pausing freezes prescaler phase. Resuming completes the remaining cycles of the interrupted second.
- `adj` rising: first `adj_step` after CLK_HZ/ADJ_HZ cycles, then every CLK_HZ/ADJ_HZ cycles.
- `adj` falling: second prescaler resumes from its held phase.
- `lap` in cycle N: `lap_min`/`lap_sec`/`lap_valid` valid after the N edge.
- `clr` in cycle N: all state cleared after the N edge.
- Asynchronous reset mid-second or mid-adjust discards all state, including prescaler phase.

## Test plan
- Up count: CLK_HZ=10, reset, run 600 cycles.
  - → `tick_1hz` every 10 cycles; 01:00 reached on the 60th tick.
  - → seconds 59→0 carries to minutes.
- Up limit: MIN_MAX=1, run to 01:59 plus one tick.
  - → time holds 01:59, `expired`=1, no further `tick_1hz`.
  - → `clr` → 00:00, `expired`=0.
- Countdown: CLK_HZ=10, ADJ_HZ=2, `adj`=1 `sel`=1 for 10 cycles.
  - → 2 steps → 00:02.
  - Then `adj`=0, `dir`=1 → 00:01, 00:00 at ticks 1 and 2, `expired`=1 with tick 2.
- Pause phase: pause at prescaler count 6 for 37 cycles.
  - → next update exactly 4 unpaused cycles after release.
- Lap/tick collision: `lap` in the same cycle as a 00:09→00:10 tick.
  - → `lap_sec`=9, `seconds`=10, `lap_valid`=1.
  - `clr`+`lap` together → `lap_valid`=0.
- Adjust wrap: `sel`=0 at minutes=MIN_MAX.
  - → next step 0, seconds unchanged.
  - `rst` low mid-adjust → all outputs 0 immediately.
